score_digit_overlay: RTL
========================

Name: score_digit_overlay

Overview:
- Downstream consumer of the four BCD score digits (score3 = thousands … score0 = units) produced by the game's score counter.
- Renders them as 7-segment-style glyphs at a fixed screen location.
- Outputs a per-pixel score_on flag to the colour mapper for the current DrawX/DrawY.
- Digits are shadowed once per frame to prevent tearing; lookup is a 2-stage pipeline.

Parameters:
X0, 560, left x of digit cell 0 (thousands)
Y0, 16, top y of all digit cells
DIG_W, 16, cell width in pixels (multiple of 4)
DIG_H, 32, cell height in pixels (multiple of 4)
GAP, 4, horizontal pixels between adjacent cells

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-low reset (0 = reset)
frame_clk  input  1  vertical-sync-rate frame strobe, synchronous to Clk
DrawX  input  10  current pixel x
DrawY  input  10  current pixel y
score0  input  4  units digit
score1  input  4  tens digit
score2  input  4  hundreds digit
score3  input  4  thousands digit
score_on  output  1  pixel belongs to a lit segment; 2-cycle latency

Behaviour:
- **Reset (asynchronous, active-low)**
  - Asserting Reset immediately clears all registers: frame_clk_delayed, shadow digits, blank flags, pipeline stages.
  - score_on = 0 during reset.
  - Reset mid-operation is legal; score_on drops to 0 without waiting for Clk.
- **Frame latch**
  - frame_clk is registered each Clk; rising edge = frame_clk & ~frame_clk_delayed.
  - On the edge cycle, score3..score0 are captured into shadow registers.
  - Blank flags are computed and registered in the same cycle.
  - Shadow values change on no other cycle.
  - After reset, shadows = 0, so the display shows a single "0" in the units cell.
- **Blanking rules**
  - Any digit with value > 9 is blank.
  - blank3 = (s3 == 0).
  - blank2 = blank3 & (s2 == 0).
  - blank1 = blank2 & (s1 == 0).
  - Units cell is never blanked, except when its value is > 9.
- **Pipeline stage 1** (registered on Clk):
  - Cell i (i = 0..3) spans x in [X0 + i*(DIG_W+GAP), X0 + i*(DIG_W+GAP) + DIG_W - 1] and y in [Y0, Y0 + DIG_H - 1].
  - Register: in_cell, cell index, local lx = DrawX − cell left, local ly = DrawY − Y0.
  - Membership uses comparisons only; no divider.
  - DrawX < X0 or DrawY < Y0 must not wrap into a hit.
  - Gap pixels give in_cell = 0.
  - Cell 0 shows shadow s3, cell 3 shows s0.
- **Pipeline stage 2** (registered on Clk):
  - score_on = in_cell & ~blank(cell) & (any lit segment covers (lx, ly)).
  - T = DIG_W/4 and H2 = DIG_H/2.
  - Segment regions:
    - a: ly < T
    - d: ly ≥ DIG_H − T
    - g: H2 − T/2 ≤ ly < H2 + T/2
    - f: lx < T, ly < H2
    - b: lx ≥ DIG_W − T, ly < H2
    - e: lx < T, ly ≥ H2
    - c: lx ≥ DIG_W − T, ly ≥ H2
  - Segment sets per digit:
    - 0 = abcdef
    - 1 = bc
    - 2 = abdeg
    - 3 = abcdg
    - 4 = bcfg
    - 5 = acdfg
    - 6 = acdefg
    - 7 = abc
    - 8 = abcdefg
    - 9 = abcdfg
- **Timing**
  - Latency DrawX/DrawY → score_on is exactly 2 Clk cycles; one result per cycle, no stalls.
  - The shadow/blank values used are those registered at the stage-2 clock edge.
  - A frame_clk edge coinciding with a lookup affects lookups whose stage 2 occurs after the shadow update.
- **Widths and arithmetic**
  - All geometry arithmetic is 10-bit unsigned, with the out-of-range guards above.

Test Plan:
1. **Reset and initial display (default parameters):** assert Reset = 0 mid-stream → score_on = 0 immediately. Release Reset, drive (620,17) → score_on = 1 two cycles later (units "0", segment a). Drive (560,17) → 0 (thousands blank).
2. **Frame shadowing:** set score = 1,2,3,4 (s3..s0) with no frame_clk edge → (560,20) still 0. After a frame_clk rising edge: (572,20) → 1 (digit 1, segment b); (560,17) → 0 (segment a off for "1"); (580,17) → 1 (digit 2, segment a).
3. **Latency:** single-cycle DrawX/DrawY = (620,17) among off-screen coordinates → score_on high on exactly the 2nd Clk edge after, low otherwise. Back-to-back coordinates stream correctly every cycle.
4. **Leading-zero blanking:** latch 0,0,7,0 → (560,17) = 0 and (580,17) = 0; (600,17) = 1 ("7", segment a); (624,33) = 0 ("0" has no segment g).
5. **Boundaries:** with score 8,8,8,8 latched:
   - (576,17), (559,17), (620,15) and (620,48) → 0.
   - (635,47) → 1.
   - Latch s0 = 12 → (620,17) = 0.

Source files
------------

// File: rtl/score_digit_overlay_if.sv
// Pixel-query bundle between the raster/score sources and the score digit overlay.
interface score_digit_overlay_if;
  logic       frame_clk;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [3:0] score0;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [3:0] score3;
  logic       score_on;

  modport master (
    output frame_clk, DrawX, DrawY, score0, score1, score2, score3,
    input  score_on
  );

  modport slave (
    input  frame_clk, DrawX, DrawY, score0, score1, score2, score3,
    output score_on
  );
endinterface

// File: rtl/score_digit_overlay.sv
// Four-digit 7-segment score overlay: per-frame digit shadowing, 2-stage pixel lookup.
module score_digit_overlay #(
  parameter int unsigned X0    = 560,
  parameter int unsigned Y0    = 16,
  parameter int unsigned DIG_W = 16,
  parameter int unsigned DIG_H = 32,
  parameter int unsigned GAP   = 4
) (
  input logic                  Clk,
  input logic                  Reset,
  score_digit_overlay_if.slave bus
);

  localparam int unsigned Pitch = DIG_W + GAP;
  localparam int unsigned T     = DIG_W / 4;
  localparam int unsigned H2    = DIG_H / 2;

  localparam logic [9:0] SegT   = 10'(T);
  localparam logic [9:0] RightX = 10'(DIG_W - T);
  localparam logic [9:0] BotY   = 10'(DIG_H - T);
  localparam logic [9:0] MidY   = 10'(H2);
  localparam logic [9:0] GLo    = 10'(H2 - T / 2);
  localparam logic [9:0] GHi    = 10'(H2 + T / 2);

  // Segment mask order is {a, b, c, d, e, f, g}; non-decimal values light nothing.
  function automatic logic [6:0] seg_mask(input logic [3:0] d);
    logic [6:0] m;
    unique case (d)
      4'd0:    m = 7'b1111110;
      4'd1:    m = 7'b0110000;
      4'd2:    m = 7'b1101101;
      4'd3:    m = 7'b1111001;
      4'd4:    m = 7'b0110011;
      4'd5:    m = 7'b1011011;
      4'd6:    m = 7'b1011111;
      4'd7:    m = 7'b1110000;
      4'd8:    m = 7'b1111111;
      4'd9:    m = 7'b1111011;
      default: m = 7'b0000000;
    endcase
    return m;
  endfunction

  logic             frame_q;
  logic             frame_edge;
  // Indexed by cell: cell 0 holds the thousands digit, cell 3 the units digit.
  logic [3:0][3:0]  digit_q;
  logic [3:0]       blank_q;
  logic [3:0]       blank_d;

  logic             in_cell_q, in_cell_d;
  logic [1:0]       cell_q, cell_d;
  logic [9:0]       lx_q, lx_d;
  logic [9:0]       ly_q, ly_d;
  logic             score_on_q, score_on_d;

  logic [31:0]      x_w, y_w;
  logic             y_hit;
  logic [3:0]       cur_digit;
  logic [6:0]       region;

  assign frame_edge = bus.frame_clk & ~frame_q;
  assign x_w        = 32'(bus.DrawX);
  assign y_w        = 32'(bus.DrawY);

  // Leading-zero suppression chains from the thousands cell toward the units cell.
  always_comb begin
    blank_d    = '0;
    blank_d[0] = (bus.score3 == 4'd0) | (bus.score3 > 4'd9);
    blank_d[1] = (blank_d[0] & (bus.score2 == 4'd0)) | (bus.score2 > 4'd9);
    blank_d[2] = (blank_d[1] & (bus.score1 == 4'd0)) | (bus.score1 > 4'd9);
    blank_d[3] = bus.score0 > 4'd9;
  end

  // Compare in 32 bits so coordinates left of / above the window never wrap into a hit.
  always_comb begin
    in_cell_d = 1'b0;
    cell_d    = 2'd0;
    lx_d      = 10'd0;
    y_hit     = (y_w >= Y0) && (y_w < Y0 + DIG_H);
    ly_d      = bus.DrawY - 10'(Y0);
    for (int unsigned i = 0; i < 4; i++) begin
      if ((x_w >= X0 + i * Pitch) && (x_w < X0 + i * Pitch + DIG_W)) begin
        in_cell_d = y_hit;
        cell_d    = 2'(i);
        lx_d      = bus.DrawX - 10'(X0 + i * Pitch);
      end
    end
  end

  always_comb begin
    cur_digit  = digit_q[cell_q];
    region     = '0;
    region[6]  = ly_q < SegT;
    region[5]  = (lx_q >= RightX) && (ly_q < MidY);
    region[4]  = (lx_q >= RightX) && (ly_q >= MidY);
    region[3]  = ly_q >= BotY;
    region[2]  = (lx_q < SegT) && (ly_q >= MidY);
    region[1]  = (lx_q < SegT) && (ly_q < MidY);
    region[0]  = (ly_q >= GLo) && (ly_q < GHi);
    score_on_d = in_cell_q & ~blank_q[cell_q] & (|(seg_mask(cur_digit) & region));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_q    <= 1'b0;
      digit_q    <= '0;
      blank_q    <= 4'b0111;
      in_cell_q  <= 1'b0;
      cell_q     <= 2'd0;
      lx_q       <= 10'd0;
      ly_q       <= 10'd0;
      score_on_q <= 1'b0;
    end else begin
      frame_q <= bus.frame_clk;
      if (frame_edge) begin
        digit_q[0] <= bus.score3;
        digit_q[1] <= bus.score2;
        digit_q[2] <= bus.score1;
        digit_q[3] <= bus.score0;
        blank_q    <= blank_d;
      end
      in_cell_q  <= in_cell_d;
      cell_q     <= cell_d;
      lx_q       <= lx_d;
      ly_q       <= ly_d;
      score_on_q <= score_on_d;
    end
  end

  assign bus.score_on = score_on_q;

endmodule
